store_buffer_dmem: RTL and testbench

STORE_BUFFER_DMEM -- requirements
Module: store_buffer_dmem

---
 rtl/store_buffer_dmem.sv | 153 +++++++++++++++
 tb/tb_store_buffer_dmem.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer_dmem.sv
// store_buffer_dmem: posted-store FIFO in front of a single-port data memory.
// Loads forward from buffered stores, otherwise stall for one backing read.
module store_buffer_dmem #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memwriteM,
    input  logic        memreadM,
    input  logic [31:0] alumultoutM,
    input  logic [31:0] writedataM,
    output logic [31:0] readdataM,
    output logic        stallM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [PW:0]   count_q, count_d;
    logic [29:0]   addr_q [DEPTH];
    logic [29:0]   addr_d [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [31:0]   data_d [DEPTH];

    logic [29:0]   word_addr;
    logic          store;
    logic          load;
    logic          full;
    logic          enq;
    logic          deq;
    logic          rd_done;
    logic          fwd_hit;
    logic [31:0]   fwd_data;
    logic [PW-1:0] idx;
    logic          ld_miss;
    logic          unused_ok;

    assign word_addr = alumultoutM[31:2];
    assign unused_ok = ^alumultoutM[1:0];

    // A store wins when both requests are raised together.
    assign store   = memwriteM && !rst;
    assign load    = memreadM && !memwriteM && !rst;
    assign full    = (count_q == (PW+1)'(DEPTH));
    assign enq     = store && !full;
    assign deq     = (state_q == WRITE) && mem_ack;
    assign rd_done = (state_q == READ) && mem_ack;
    assign ld_miss = load && !fwd_hit;

    // Walk oldest to youngest so the youngest matching entry wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (((PW+1)'(i) < count_q) && (addr_q[idx] == word_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[idx];
            end
        end
    end

    always_comb begin
        stallM    = 1'b0;
        readdataM = '0;
        if (store) begin
            stallM = full;
        end else if (load && fwd_hit) begin
            readdataM = fwd_data;
        end else if (ld_miss) begin
            stallM = !rd_done;
            if (rd_done) readdataM = mem_rdata;
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (enq) begin
            addr_d[tail_q] = word_addr;
            data_d[tail_q] = writedataM;
            tail_d         = tail_q + PW'(1);
        end
        if (deq) head_d = head_q + PW'(1);
        count_d = count_q + (PW+1)'(enq) - (PW+1)'(deq);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage needs no reset: count_q alone defines validity.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (ld_miss) state_d = READ;
                else if (count_q != '0) state_d = WRITE;
            end
            WRITE: if (mem_ack) state_d = IDLE;
            READ:  if (mem_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (state_q)
            WRITE: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = addr_q[head_q];
                mem_wdata = data_q[head_q];
            end
            READ: begin
                mem_req  = 1'b1;
                mem_addr = word_addr;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_store_buffer_dmem.sv
// tb_store_buffer_dmem: scoreboard bench for the store buffer.
// Queues hold buffered stores and expected load data.
module tb_store_buffer_dmem;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        memwriteM;
    logic        memreadM;
    logic [31:0] alumultoutM;
    logic [31:0] writedataM;
    logic [31:0] readdataM;
    logic        stallM;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    typedef struct packed {
        logic [29:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t         wq[$];
    logic [31:0] rq[$];
    logic [31:0] bm [logic [29:0]];

    int n_vec = 0;
    int n_err = 0;
    int mcnt  = 0;
    int wcnt  = 0;
    int lat   = 2;
    bit ack_on  = 1'b0;
    bit man_ack = 1'b0;

    logic        s_stall, s_req, s_we, s_ack, s_exp_st;
    logic [29:0] s_addr;
    logic [31:0] s_wdata;

    store_buffer_dmem #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .memwriteM(memwriteM), .memreadM(memreadM),
        .alumultoutM(alumultoutM), .writedataM(writedataM),
        .readdataM(readdataM), .stallM(stallM),
        .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] bm_rd(input logic [29:0] wa);
        if (bm.exists(wa)) return bm[wa];
        return {wa[15:0], ~wa[15:0]};
    endfunction

    task automatic exp_load(input logic [31:0] a, output logic [31:0] e,
                            output logic hit);
        hit = 1'b0;
        e   = bm_rd(a[31:2]);
        for (int i = 0; i < wq.size(); i++)
            if (wq[i].a == a[31:2]) begin
                e   = wq[i].d;
                hit = 1'b1;
            end
    endtask

    // One clock: drive, answer memory, sample at negedge, score.
    task automatic cyc(input logic w, input logic r, input logic [31:0] a,
                       input logic [31:0] d, input logic rs);
        logic wack;
        wr_t  x;
        rst = rs; memwriteM = w; memreadM = r;
        alumultoutM = a; writedataM = d;
        #1;
        mem_ack = man_ack;
        if (!mem_req) wcnt = 0;
        else if (ack_on) begin
            if (wcnt >= lat) begin
                mem_ack = 1'b1;
                wcnt = 0;
            end else wcnt++;
        end
        mem_rdata = bm_rd(mem_addr);
        @(negedge clk);
        s_stall = stallM; s_req = mem_req; s_we = mem_we;
        s_ack = mem_ack; s_addr = mem_addr; s_wdata = mem_wdata;
        wack = mem_req && mem_we && mem_ack;
        s_exp_st = w && !rs && (mcnt == DEPTH);
        if (rs) begin
            chk("rst_stall", stallM, 0);
            chk("rst_rdata", readdataM, 0);
        end else if (w) begin
            chk("st_stall", stallM, s_exp_st);
        end else if (!r) begin
            chk("idle_stall", stallM, 0);
            chk("idle_rdata", readdataM, 0);
        end else if (!stallM) begin
            if (rq.size() == 0) chk("ld_unexpected", 1, 0);
            else chk("ld_data", readdataM, rq.pop_front());
        end
        if (rs) begin
            wq.delete();
            mcnt = 0;
        end else begin
            if (wack) begin
                if (wq.size() == 0) chk("wr_unexpected", 1, 0);
                else begin
                    x = wq.pop_front();
                    chk("wr_addr", mem_addr, x.a);
                    chk("wr_data", mem_wdata, x.d);
                    bm[x.a] = x.d;
                    mcnt--;
                end
            end
            if (w && !s_exp_st) begin
                wq.push_back({a[31:2], d});
                mcnt++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0, 0, 0);
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        for (int n = 0; n < 40; n++) begin
            cyc(1, 0, a, d, 0);
            if (!s_exp_st) return;
        end
        chk("st_timeout", 1, 0);
    endtask

    task automatic load(input logic [31:0] a, output int stall_n);
        logic [31:0] e;
        logic hit, done, rd_seen, rd_early, wr_pend;
        int wacks;
        exp_load(a, e, hit);
        rq.push_back(e);
        wr_pend = mem_req && mem_we;
        stall_n = 0; wacks = 0; done = 0;
        rd_seen = 0; rd_early = 0;
        for (int n = 0; n < 40 && !done; n++) begin
            cyc(0, 1, a, 0, 0);
            if (s_req && !s_we && wacks == 0 && wr_pend) rd_early = 1;
            if (s_req && s_we && s_ack) wacks++;
            if (s_req && !s_we) rd_seen = 1;
            if (s_stall) stall_n++;
            else done = 1;
        end
        if (!done) begin
            chk("ld_timeout", 1, 0);
            rq.delete();
        end else if (hit) begin
            chk("fwd_stall", stall_n, 0);
            chk("fwd_noread", rd_seen, 0);
        end else begin
            chk("miss_rdack", s_ack && s_req && !s_we, 1);
            if (wr_pend) chk("wr_first", rd_early, 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        int sn;
        rst = 1; memwriteM = 0; memreadM = 0;
        alumultoutM = 0; writedataM = 0;
        mem_ack = 0; mem_rdata = 0;
        @(posedge clk);
        #1;
        cyc(0, 0, 0, 0, 1);
        chk("rst_req", s_req, 0);
        chk("rst_we", s_we, 0);
        chk("rst_addr", s_addr, 0);
        chk("rst_wdata", s_wdata, 0);
        cyc(0, 1, 32'h300, 0, 1);
        ack_on = 1; lat = 2;
        idle(2);

        store(32'h100, 32'hAAAA5555);
        load(32'h102, sn);

        store(32'h200, 32'h1);
        store(32'h200, 32'h2);
        load(32'h200, sn);
        idle(20);

        bm[30'h0C0] = 32'h12345678;
        load(32'h300, sn);
        chk("miss_stall_n", sn, 3);

        lat = 3;
        store(32'h500, 32'hCAFE0001);
        idle(1);
        load(32'h400, sn);
        idle(20);

        ack_on = 0;
        for (int i = 0; i < 4; i++) store(32'h800 + 4 * i, 32'h8000 + i);
        cyc(1, 0, 32'h810, 32'h8888, 0);
        chk("full_stall", s_stall, 1);
        man_ack = 1;
        cyc(1, 0, 32'h810, 32'h8888, 0);
        chk("ack_same_cyc", s_stall, 1);
        man_ack = 0;
        cyc(1, 0, 32'h810, 32'h8888, 0);
        chk("admit_next", s_stall, 0);
        cyc(1, 0, 32'h814, 32'h9999, 0);
        chk("count_full", s_stall, 1);
        ack_on = 1;
        store(32'h814, 32'h9999);
        idle(30);

        ack_on = 0;
        for (int i = 0; i < 3; i++) store(32'h900 + 4 * i, 32'h9000 + i);
        cyc(0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) store(32'hA00 + 4 * i, 32'hA000 + i);
        ack_on = 1;
        load(32'h904, sn);
        idle(30);

        ack_on = 0;
        cyc(0, 1, 32'h600, 0, 0);
        cyc(0, 1, 32'h600, 0, 0);
        chk("rd_req", s_req, 1);
        chk("rd_we", s_we, 0);
        chk("rd_addr", s_addr, 30'h180);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        chk("post_rst_req", s_req, 0);
        man_ack = 1;
        cyc(0, 0, 0, 0, 0);
        man_ack = 0;
        cyc(0, 0, 0, 0, 0);
        chk("stray_req", s_req, 0);
        ack_on = 1;
        load(32'h600, sn);

        for (int k = 0; k < 40; k++) begin
            logic [31:0] a;
            a = 32'h700 + 32'($urandom_range(0, 5)) * 4
                + 32'($urandom_range(0, 3));
            lat = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) store(a, $urandom);
            else load(a, sn);
        end
        idle(40);
        chk("drain", wq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
